osc_sel_decoder_bbm: RTL
========================

# osc_sel_decoder_bbm

Parametrised, registered N-to-2^N select decoder with break-before-make switching and an optional auto-scan mode. It drives the oscillator trim/tap select switches, so two select lines are never active in the same cycle. On every code change all lines are released for a programmable dead time before the new line is asserted. It replaces the fixed 3-to-8 combinational select decoding in the regulator/oscillator design.

## Interface
- SEL_W, 3: select code width; outputs = 2**SEL_W (legal 1..6)
- DEAD_CYC, 2: break (all-inactive) cycles on each code change (legal ≥1)
- SCAN_DIV, 4: ON dwell cycles per code in scan mode (legal ≥1)
- ACTIVE_LOW, 1: 1 = active line driven 0, inactive 1; 0 = inverse polarity
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  enable; low forces all lines inactive
- sel  in  SEL_W  requested code (used when scan_en=0)
- scan_en  in  1  1 = step code automatically; sel ignored
- y  out  2**SEL_W  registered select lines, at most one active
- cur_sel  out  SEL_W  code currently driven or last driven
- busy  out  1  high while in BREAK

## Operation
- Reset values: state OFF; y all inactive (all 1s when ACTIVE_LOW=1); cur_sel=0; busy=0; dead counter=0; scan divider=0; scan target=0.
- target = scan_tgt when scan_en=1, else sel.
- OFF: y inactive. If en=1: cur_sel<=target, go ON.
- ON: exactly one active line, index cur_sel.
  - en=0: go OFF.
  - else if target≠cur_sel: go BREAK, cnt<=DEAD_CYC-1, pend<=target.
- BREAK: y inactive, busy=1.
  - en=0: go OFF; pend discarded.
  - else pend<=target each cycle (latest wins).
  - cnt==0: cur_sel<=pend, go ON. Otherwise cnt decrements.
  - If target returns to the old cur_sel mid-break, the break still completes.
- Scan mode:
  - While ON and scan_en=1, the divider counts 0..SCAN_DIV-1. At terminal, scan_tgt<=cur_sel+1 mod 2**SEL_W (wraps max→0), which triggers BREAK.
  - The divider clears to 0 outside ON.
  - On the rising edge of scan_en, scan_tgt<=cur_sel, so there is no jump.
  - Falling scan_en with sel≠cur_sel is an ordinary code change.
- Priority: rst > en=0 > dead-time completion > code change.
- y, busy and cur_sel are all flop outputs. No combinational path from inputs to y.

## Timing
- OFF→ON: en and sel sampled at edge k; y active from edge k+1 (latency 1).
- Code change sampled at edge k while ON:
  - y all inactive from k+1 through k+DEAD_CYC.
  - New line active from edge k+DEAD_CYC+1.
  - busy high over the same cycles as the break.
- en low sampled at edge k: y inactive from k+1 in any state.
- Scan period per code = SCAN_DIV (ON) + DEAD_CYC (BREAK) cycles.
- Async rst mid-BREAK or mid-ON: y inactive immediately, without waiting for a clock edge. After rst deasserts, the block resumes from OFF.

## Structure
- Package osc_sel_pkg holds:
  - state encoding: OFF, ON, BREAK (2-bit localparams)
  - polarity helper constant derived from ACTIVE_LOW
- Sub-module osc_onehot_dec: combinational SEL_W→2**SEL_W one-hot decode with an enable input and polarity parameter. Its output feeds the y register.
- Top holds the FSM, dead counter, scan divider, scan_tgt and pend registers.

## Test plan
- Reset/enable (defaults): rst=1 → y=8'hFF, cur_sel=0, busy=0; release rst, en=1, sel=3 → y=8'hF7 one cycle later.
- Break-before-make (DEAD_CYC=2): ON at sel=3; sel=5 at edge k → y=FF and busy=1 at k+1 and k+2; y=8'hDF at k+3.
- Latest wins / return (DEAD_CYC=3): during BREAK, sel goes 5→6 → final y=8'hBF. Separately, sel returns to old code mid-break → full break still occurs, then the old line reasserts.
- Scan wrap (SCAN_DIV=4, DEAD_CYC=1, start cur_sel=7): scan_en=1 → 4 cycles y=8'h7F, 1 cycle FF, then y=8'hFE with cur_sel=0.
- Disable and async reset mid-operation: en=0 during BREAK → OFF, y=FF next cycle, no line asserted. rst pulsed mid-ON, not clock-aligned → y=FF before the next clk edge.
- Parameter sweep: SEL_W=1 and 4, ACTIVE_LOW=0. Check at every cycle that at most one bit of y is active, and that active-line changes are always separated by ≥DEAD_CYC all-inactive cycles.

Source files
------------

// File: rtl/osc_sel_pkg.sv
// Shared definitions for the break-before-make oscillator select decoder:
// FSM state encoding and select-line polarity helpers.
package osc_sel_pkg;

    // Controller states
    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_ON    = 2'd1;
    localparam logic [1:0] ST_BREAK = 2'd2;

    // Physical level of a select line given its logical activity and polarity
    function automatic logic line_level(input logic active, input bit active_low);
        return active ^ active_low;
    endfunction

    // Physical level of a released (inactive) select line
    function automatic logic idle_level(input bit active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/osc_onehot_dec.sv
// Combinational one-hot decoder: SEL_W-bit code to 2**SEL_W select lines,
// all lines forced inactive when i_en is low. Polarity set by ACTIVE_LOW.
module osc_onehot_dec
    import osc_sel_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [SEL_W-1:0]      i_code,
    input  logic                  i_en,
    output logic [2**SEL_W-1:0]   o_lines
);

    genvar gi;
    generate
        for (gi = 0; gi < 2**SEL_W; gi++) begin : g_line
            assign o_lines[gi] = line_level(i_en && (i_code == SEL_W'(gi)), ACTIVE_LOW);
        end
    endgenerate

endmodule

// File: rtl/osc_sel_decoder_bbm.sv
// Registered N-to-2**N select decoder with break-before-make dead time and
// an optional auto-scan mode that steps through every code in turn.
module osc_sel_decoder_bbm
    import osc_sel_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DEAD_CYC   = 2,
    parameter int SCAN_DIV   = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  scan_en,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  busy
);

    localparam int N_OUT = 2**SEL_W;
    localparam int CNT_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic IDLE = idle_level(ACTIVE_LOW);

    logic [1:0]        r_state;
    logic [SEL_W-1:0]  r_cur_sel;
    logic [SEL_W-1:0]  r_pend;
    logic [CNT_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  r_div;
    logic [SEL_W-1:0]  r_scan_tgt;
    logic              r_scan_en_d;
    logic [N_OUT-1:0]  r_y;
    logic              r_busy;

    logic [1:0]        w_state_next;
    logic [SEL_W-1:0]  w_cur_sel_next;
    logic [SEL_W-1:0]  w_pend_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [SEL_W-1:0]  w_target;
    logic [SEL_W-1:0]  w_scan_step;
    logic [N_OUT-1:0]  w_lines;
    logic              w_scan_rise;
    logic              w_scan_count;
    logic              w_scan_term;

    // Entering scan mode holds the current code; the dwell divider only runs
    // while a line is driven and scan mode was already active last cycle.
    assign w_scan_rise  = scan_en & ~r_scan_en_d;
    assign w_scan_count = (r_state == ST_ON) & scan_en & r_scan_en_d;
    assign w_scan_term  = w_scan_count & (r_div == DIV_LAST);
    assign w_scan_step  = r_cur_sel + 1'b1;

    // Requested code: the terminal dwell cycle requests the next code directly
    // so the ON dwell is exactly SCAN_DIV cycles.
    always_comb begin
        w_target = r_scan_tgt;
        if (!scan_en)
            w_target = sel;
        else if (w_scan_rise)
            w_target = r_cur_sel;
        else if (w_scan_term)
            w_target = w_scan_step;
    end

    // Next-state logic: disable beats dead-time completion beats code change
    always_comb begin
        w_state_next   = r_state;
        w_cur_sel_next = r_cur_sel;
        w_pend_next    = r_pend;
        w_cnt_next     = r_cnt;
        case (r_state)
            ST_OFF: begin
                if (en) begin
                    w_cur_sel_next = w_target;
                    w_state_next   = ST_ON;
                end
            end
            ST_ON: begin
                if (!en) begin
                    w_state_next = ST_OFF;
                end else if (w_target != r_cur_sel) begin
                    w_state_next = ST_BREAK;
                    w_cnt_next   = CNT_LOAD;
                    w_pend_next  = w_target;
                end
            end
            ST_BREAK: begin
                if (!en) begin
                    w_state_next = ST_OFF;
                end else begin
                    w_pend_next = w_target;
                    if (r_cnt == '0) begin
                        w_cur_sel_next = r_pend;
                        w_state_next   = ST_ON;
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
            end
            default: w_state_next = ST_OFF;
        endcase
    end

    // Decode from next-state values so y is a pure flop output
    osc_onehot_dec #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .i_code  (w_cur_sel_next),
        .i_en    (w_state_next == ST_ON),
        .o_lines (w_lines)
    );

    // FSM, dead-time counter and select-line registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_OFF;
            r_cur_sel <= '0;
            r_pend    <= '0;
            r_cnt     <= '0;
            r_y       <= {N_OUT{IDLE}};
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cur_sel <= w_cur_sel_next;
            r_pend    <= w_pend_next;
            r_cnt     <= w_cnt_next;
            r_y       <= w_lines;
            r_busy    <= (w_state_next == ST_BREAK);
        end
    end

    // Scan dwell divider and scan target tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div       <= '0;
            r_scan_tgt  <= '0;
            r_scan_en_d <= 1'b0;
        end else begin
            r_scan_en_d <= scan_en;
            if (w_scan_rise)
                r_scan_tgt <= r_cur_sel;
            else if (w_scan_term)
                r_scan_tgt <= w_scan_step;
            if (w_scan_count && !w_scan_term)
                r_div <= r_div + 1'b1;
            else
                r_div <= '0;
        end
    end

    assign y       = r_y;
    assign cur_sel = r_cur_sel;
    assign busy    = r_busy;

endmodule
